// File: rtl/mm_bridge_host.sv
// mm_bridge_host
//   Host-side sequencer for the BRAM shared with the Montgomery multiplier.
//   Loads p_prime_0, p, a, b from an operand stream into the BRAM, kicks the
//   multiplier, waits for done (optionally with a timeout), then reads the s
//   result sections back and streams them out with valid/ready.
//
//   Ports
//     clock_i, reset_n_i            clock, async active-low reset
//     op_data_i/op_valid_i/op_ready_o   operand stream in (17-bit words)
//     res_data_o/res_valid_o/res_ready_i  result stream out, LS section first
//     mm_start_o, mm_done_i         multiplier handshake
//     bram_addr_o/din_o/dout_i/we_o/en_o  host BRAM port
//     busy_o, done_o, err_o         status (done is a pulse, err is sticky)
//
//   state      | meaning
//   ST_IDLE    | ready for p_prime_0; first accepted word starts a load
//   ST_LOAD    | writing p, a, b sections as operands arrive
//   ST_KICK    | one-cycle start pulse to the multiplier
//   ST_WAIT    | multiplier owns the BRAM; wait for done or timeout
//   ST_RD_REQ  | issue read of result section idx
//   ST_RD_WAIT | cover BRAM read latency, capture data
//   ST_OUT     | present captured section until accepted
module mm_bridge_host #(
  parameter int s        = 8,
  parameter int RD_LAT   = 1,
  parameter int PP0_ADDR = 0,
  parameter int P_BASE   = 1,
  parameter int A_BASE   = s + 1,
  parameter int B_BASE   = 2 * s + 1,
  parameter int RES_BASE = s + 1,
  parameter int TIMEOUT  = 0
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic [16:0] op_data_i,
  input  logic        op_valid_i,
  output logic        op_ready_o,
  output logic [16:0] res_data_o,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic        mm_start_o,
  input  logic        mm_done_i,
  output logic [31:0] bram_addr_o,
  output logic [16:0] bram_din_o,
  input  logic [16:0] bram_dout_i,
  output logic        bram_we_o,
  output logic        bram_en_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int WCW = $clog2(3 * s + 1);
  localparam int IW  = $clog2(s + 1);
  localparam int LW  = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_KICK, ST_WAIT, ST_RD_REQ, ST_RD_WAIT, ST_OUT
  } state_t;

  state_t          state_q, state_d;
  logic [WCW-1:0]  word_cnt_q, word_cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [31:0]     tmo_q, tmo_d;
  logic [16:0]     res_q, res_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            alive_q;
  logic [31:0]     k32;
  logic [31:0]     load_addr;

  // alive_q keeps op_ready_o low while reset is asserted so that every
  // output reads 0 during reset; it rises on the first clock afterwards.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      idx_q      <= '0;
      lat_q      <= '0;
      tmo_q      <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      alive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      idx_q      <= idx_d;
      lat_q      <= lat_d;
      tmo_q      <= tmo_d;
      res_q      <= res_d;
      err_q      <= err_d;
      done_q     <= done_d;
      alive_q    <= 1'b1;
    end
  end

  // Section map for operand word k (k >= 1 while in LOAD).
  always_comb begin
    k32 = 32'(word_cnt_q);
    if (k32 == 32'd0)
      load_addr = 32'(PP0_ADDR);
    else if (k32 <= 32'(s))
      load_addr = 32'(P_BASE) + k32 - 32'd1;
    else if (k32 <= 32'(2 * s))
      load_addr = 32'(A_BASE) + k32 - 32'(s + 1);
    else
      load_addr = 32'(B_BASE) + k32 - 32'(2 * s + 1);
  end

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    idx_d       = idx_q;
    lat_d       = lat_q;
    tmo_d       = tmo_q;
    res_d       = res_q;
    err_d       = err_q;
    done_d      = 1'b0;
    op_ready_o  = 1'b0;
    res_valid_o = 1'b0;
    mm_start_o  = 1'b0;
    bram_addr_o = '0;
    bram_din_o  = '0;
    bram_we_o   = 1'b0;
    bram_en_o   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        op_ready_o = alive_q;
        if (alive_q && op_valid_i) begin
          bram_en_o   = 1'b1;
          bram_we_o   = 1'b1;
          bram_addr_o = 32'(PP0_ADDR);
          bram_din_o  = op_data_i;
          err_d       = 1'b0;
          word_cnt_d  = WCW'(1);
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        op_ready_o = 1'b1;
        if (op_valid_i) begin
          bram_en_o   = 1'b1;
          bram_we_o   = 1'b1;
          bram_addr_o = load_addr;
          bram_din_o  = op_data_i;
          if (word_cnt_q == WCW'(3 * s)) begin
            word_cnt_d = '0;
            state_d    = ST_KICK;
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end
      end
      ST_KICK: begin
        mm_start_o = 1'b1;
        tmo_d      = 32'(TIMEOUT - 1);
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // done has priority over a timeout expiring in the same cycle
        if (mm_done_i) begin
          idx_d   = '0;
          state_d = ST_RD_REQ;
        end else if (TIMEOUT > 0) begin
          if (tmo_q == 32'd0) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tmo_d = tmo_q - 32'd1;
          end
        end
      end
      ST_RD_REQ: begin
        bram_en_o   = 1'b1;
        bram_addr_o = 32'(RES_BASE) + 32'(idx_q);
        lat_d       = LW'(RD_LAT - 1);
        state_d     = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (lat_q == '0) begin
          res_d   = bram_dout_i;
          state_d = ST_OUT;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      ST_OUT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) begin
          if (idx_q == IW'(s - 1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ST_RD_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign res_data_o = res_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_mm_bridge_host.sv
module tb_mm_bridge_host;

  localparam int S        = 8;
  localparam int PP0      = 0;
  localparam int P_BASE   = 1;
  localparam int A_BASE   = S + 1;
  localparam int B_BASE   = 2 * S + 1;
  localparam int RES_BASE = S + 1;
  localparam int TMO      = 100;
  localparam int NWORDS   = 3 * S + 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [16:0] op_data;
  logic        op_valid;
  logic        op_ready_o;
  logic [16:0] res_data_o;
  logic        res_valid_o;
  logic        res_ready;
  logic        mm_start_o;
  logic        mm_done;
  logic [31:0] bram_addr_o;
  logic [16:0] bram_din_o;
  logic [16:0] bram_dout;
  logic        bram_we_o;
  logic        bram_en_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  always #5 clk = ~clk;

  mm_bridge_host #(.s(S), .TIMEOUT(TMO)) dut (
    .clock_i(clk), .reset_n_i(reset_n),
    .op_data_i(op_data), .op_valid_i(op_valid), .op_ready_o(op_ready_o),
    .res_data_o(res_data_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready),
    .mm_start_o(mm_start_o), .mm_done_i(mm_done),
    .bram_addr_o(bram_addr_o), .bram_din_o(bram_din_o), .bram_dout_i(bram_dout),
    .bram_we_o(bram_we_o), .bram_en_o(bram_en_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int addr_of(input int k);
    if (k == 0) return PP0;
    if (k <= S) return P_BASE + k - 1;
    if (k <= 2 * S) return A_BASE + k - S - 1;
    return B_BASE + k - 2 * S - 1;
  endfunction

  // Scoreboard queues
  int          exp_wa[$];
  logic [16:0] exp_wd[$];
  int          exp_rd[$];
  logic [16:0] exp_res[$];

  // BRAM model: host port from the DUT plus a preload port for the multiplier model
  logic [16:0] mem [0:31];
  logic        pl_we = 1'b0;
  logic [4:0]  pl_addr = '0;
  logic [16:0] pl_data = '0;
  logic [16:0] rdata = '0;
  assign bram_dout = rdata;

  always @(posedge clk) begin
    if (bram_en_o) begin
      if (bram_we_o) mem[bram_addr_o[4:0]] <= bram_din_o;
      else           rdata <= mem[bram_addr_o[4:0]];
    end
    if (pl_we) mem[pl_addr] <= pl_data;
  end

  // Multiplier model: on start, store s result sections then pulse done
  int mm_mode  = 0;   // 0 random data, 1 fixed 0x1AAAA+i, 2 never done
  int mm_delay = 20;

  initial begin
    mm_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && mm_start_o && mm_mode != 2) begin
        for (int p = 1; p <= mm_delay; p++) begin
          @(posedge clk); #1;
          pl_we = (p <= S);
          if (p <= S) begin
            pl_addr = 5'(RES_BASE + p - 1);
            pl_data = (mm_mode == 1) ? 17'(32'h1AAAA + p - 1) : 17'($urandom);
            exp_res.push_back(pl_data);
            exp_rd.push_back(RES_BASE + p - 1);
          end
          mm_done = (p == mm_delay);
        end
        @(posedge clk); #1;
        mm_done = 1'b0;
        pl_we   = 1'b0;
      end
    end
  end

  // Result-ready driver
  int rdy_mode = 0;   // 0 always ready, 1 random, 2 stall word 3 for 5 cycles
  int drv_idx  = 0;
  int held     = 0;
  logic pv = 1'b0, pr = 1'b0;

  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (pv && pr) drv_idx++;
      case (rdy_mode)
        0: res_ready = 1'b1;
        1: res_ready = 1'($urandom_range(0, 1));
        default: begin
          if (drv_idx == 3 && held < 5) begin
            res_ready = 1'b0;
            if (res_valid_o) held++;
          end else begin
            res_ready = 1'b1;
          end
        end
      endcase
      pv = res_valid_o;
      pr = res_ready;
    end
  end

  // Monitor
  int          n_acc = 0;
  int          n_res = 0;
  bit          exp_start = 1'b0;
  bit          exp_done = 1'b0;
  bit          hold = 1'b0;
  logic [16:0] hold_data = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      n_acc = 0; n_res = 0; exp_start = 0; exp_done = 0; hold = 0;
    end else begin
      if (mm_start_o || exp_start) begin
        chk("start_pulse", 32'(mm_start_o), 32'(exp_start));
        if (mm_start_o) chk("ready_in_kick", 32'(op_ready_o), 32'd0);
      end
      exp_start = 1'b0;
      if (op_valid && op_ready_o) begin
        n_acc++;
        if (n_acc == NWORDS) begin
          exp_start = 1'b1;
          n_acc = 0;
        end
      end

      if (bram_en_o && bram_we_o) begin
        chk("write_on_accept", 32'(op_valid && op_ready_o), 32'd1);
        chk("write_expected", 32'(exp_wa.size() > 0), 32'd1);
        if (exp_wa.size() > 0) begin
          chk("write_addr", bram_addr_o, 32'(exp_wa.pop_front()));
          chk("write_data", 32'(bram_din_o), 32'(exp_wd.pop_front()));
        end
      end
      if (bram_en_o && !bram_we_o) begin
        chk("read_expected", 32'(exp_rd.size() > 0), 32'd1);
        if (exp_rd.size() > 0) chk("read_addr", bram_addr_o, 32'(exp_rd.pop_front()));
      end

      if (hold) begin
        chk("hold_valid", 32'(res_valid_o), 32'd1);
        chk("hold_data", 32'(res_data_o), 32'(hold_data));
        chk("hold_no_read", 32'(bram_en_o), 32'd0);
      end
      hold      = res_valid_o && !res_ready;
      hold_data = res_data_o;

      if (done_o || exp_done) chk("done_pulse", 32'(done_o), 32'(exp_done));
      exp_done = 1'b0;

      if (res_valid_o && res_ready) begin
        chk("result_expected", 32'(exp_res.size() > 0), 32'd1);
        if (exp_res.size() > 0) chk("result_data", 32'(res_data_o), 32'(exp_res.pop_front()));
        n_res++;
        if (n_res == S) begin
          exp_done = 1'b1;
          n_res = 0;
        end
      end
    end
  end

  // Stimulus helpers
  task automatic load(input int n, input int gap, input bit fixed);
    logic [16:0] d;
    bit acc;
    int ng;
    for (int k = 0; k < n; k++) begin
      d = fixed ? 17'(k + 1) : 17'($urandom);
      exp_wa.push_back(addr_of(k));
      exp_wd.push_back(d);
      op_data  = d;
      op_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
        @(negedge clk);
        acc = op_ready_o;
        @(posedge clk); #1;
      end
      if (!acc) chk("op_accept_timeout", 32'd0, 32'd1);
      if (k == 0) chk("err_cleared", 32'(err_o), 32'd0);
      op_valid = 1'b0;
      ng = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 3)) : 0;
      repeat (ng) begin
        op_data = 17'($urandom);
        @(posedge clk); #1;
      end
    end
    op_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      @(negedge clk);
      seen = done_o;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_after_done", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run(input int gap, input bit fixed, input int mmode, input int delay, input int rmode);
    mm_mode  = mmode;
    mm_delay = delay;
    rdy_mode = rmode;
    drv_idx  = 0;
    held     = 0;
    load(NWORDS, gap, fixed);
    wait_done();
    chk("no_err", 32'(err_o), 32'd0);
  endtask

  logic any_out;
  always_comb any_out = |{op_ready_o, res_valid_o, mm_start_o, bram_en_o, bram_we_o,
                          busy_o, done_o, err_o, res_data_o, bram_addr_o, bram_din_o};

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit seen;
    reset_n  = 1'b0;
    op_valid = 1'b0;
    op_data  = '0;
    #3;
    chk("reset_outputs", 32'(any_out), 32'd0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", 32'(op_ready_o), 32'd1);

    // Fixed operands, fixed results, stall on word 3
    run(0, 1'b1, 1, 20, 2);
    chk("stall_cycles", 32'(held), 32'd5);

    // Toggled valid, done exactly on the timeout boundary, random ready
    run(1, 1'b0, 0, TMO, 1);

    // Timeout: multiplier never answers
    mm_mode  = 2;
    rdy_mode = 0;
    load(NWORDS, 0, 1'b0);
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      seen = mm_start_o;
    end
    chk("tmo_start_seen", 32'(seen), 32'd1);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 300) begin
      @(negedge clk);
      cnt++;
      seen = err_o;
    end
    chk("tmo_cycles", 32'(cnt), 32'(TMO + 1));
    chk("tmo_idle", 32'(busy_o), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", 32'(err_o), 32'd1);

    // Next load clears err (checked inside load) and completes normally
    run(2, 1'b0, 0, 40, 1);

    // Reset mid-load after 10 words
    mm_mode = 0;
    load(10, 0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midload_reset_outputs", 32'(any_out), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run(0, 1'b1, 0, 15, 0);

    // Randomized runs
    for (int r = 0; r < 6; r++)
      run(int'($urandom_range(0, 2)), 1'b0, 0, int'($urandom_range(S + 1, TMO)),
          int'($urandom_range(0, 1)));

    repeat (5) @(posedge clk);
    #1;
    chk("wr_queue_empty", 32'(exp_wa.size()), 32'd0);
    chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    chk("res_queue_empty", 32'(exp_res.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_bridge_host.md
Name: mm_bridge_host

Overview:
- Host-side controller for the bridge BRAM shared with the Montgomery multiplier top.
- Accepts an operand word stream and writes p_prime_0, p, a and b sections into the BRAM over its own port.
- Pulses the multiplier start, waits for its done, then reads the s result sections back out of the BRAM and streams them out with valid/ready.
- Owns the opposite BRAM port from the multiplier. The two never access the BRAM concurrently: host access happens only outside the WAIT state.

Parameters:
- s, 8: number of 17-bit sections per operand.
- RD_LAT, 1: BRAM read latency in cycles (1 or 2).
- PP0_ADDR, 0: address of p_prime_0.
- P_BASE, 1: address of p section 0; sections at P_BASE..P_BASE+s-1.
- A_BASE, s+1: base address of a sections.
- B_BASE, 2*s+1: base address of b sections.
- RES_BASE, s+1: base address of result sections (overwrites a).
- TIMEOUT, 0: maximum cycles to wait for mm_done_i; 0 disables the timeout.

Ports:
- clock_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- op_data_i  in  17  operand word.
- op_valid_i  in  1  operand word valid.
- op_ready_o  out  1  operand word accepted when valid&ready.
- res_data_o  out  17  result section, least-significant section first.
- res_valid_o  out  1  result word valid.
- res_ready_i  in  1  result consumer ready.
- mm_start_o  out  1  one-cycle start pulse to the multiplier.
- mm_done_i  in  1  multiplier done.
- bram_addr_o  out  32  BRAM address; upper bits are zero above clog2(4*s).
- bram_din_o  out  17  BRAM write data.
- bram_dout_i  in  17  BRAM read data.
- bram_we_o  out  1  BRAM write enable.
- bram_en_o  out  1  BRAM chip enable.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse after the last result word is accepted.
- err_o  out  1  sticky timeout flag; cleared only by reset or by the first operand accepted in IDLE.

Behaviour:
- Reset (async, reset_n_i low): state=IDLE; all outputs 0; word counter 0.
- Operand order: p_prime_0, p[0..s-1], a[0..s-1], b[0..s-1]; 3s+1 words total.
- IDLE:
  - op_ready_o=1.
  - An accepted word is written the same cycle: bram_en_o=1, bram_we_o=1, bram_addr_o=PP0_ADDR, bram_din_o=op_data_i.
  - Next state LOAD, counter=1.
- LOAD:
  - op_ready_o=1; each accepted word is written combinationally that cycle.
  - Word k maps as follows: k=0 to PP0_ADDR; k in 1..s to P_BASE+k-1; k in s+1..2s to A_BASE+k-s-1; k in 2s+1..3s to B_BASE+k-2s-1.
  - No write occurs without valid.
  - After word 3s is accepted, go to KICK.
- KICK:
  - mm_start_o=1 for exactly one cycle; op_ready_o=0; BRAM port idle (en=0).
  - Next state WAIT.
- WAIT:
  - BRAM port idle (en=0, we=0).
  - On mm_done_i=1, go to RD_REQ with result index 0.
  - If TIMEOUT>0 and TIMEOUT cycles elapse without done: set err_o and return to IDLE with no results emitted.
  - mm_done_i is ignored in every other state.
- RD_REQ:
  - bram_en_o=1, we=0, addr=RES_BASE+index.
  - Go to RD_WAIT.
- RD_WAIT:
  - Wait RD_LAT cycles after the request cycle.
  - Capture bram_dout_i into the output register and go to OUT.
- OUT:
  - res_valid_o=1; res_data_o is held stable until res_ready_i=1.
  - On acceptance: if index=s-1, pulse done_o and go to IDLE; otherwise index+1 and go to RD_REQ.
- Throughput: one result word per RD_LAT+2 cycles when res_ready_i is held high.
- Latency: from the last operand accepted to mm_start_o is 1 cycle (the KICK cycle follows).
- Simultaneous events:
  - mm_done_i in the same cycle as the timeout expiry: done wins, no error.
  - res_ready_i high before res_valid_o: no effect.
- Counters are sized clog2(3*s+1) and clog2(s+1) bits. The address sum is computed at 32-bit width, so it cannot wrap within the 4*s address space.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. BRAM contents are not cleared. An in-flight multiplier operation is not aborted by this block.

Test Plan:
- Load for s=8: 25 operand words 0x00001..0x00019 with valid held high. Required: 25 consecutive writes at addresses 0..24 with din equal to the word; op_ready_o drops after word 25; mm_start_o pulses exactly once on the next cycle.
- Operand gaps: op_valid_i toggled 1/0 during the load. Required: writes occur only on valid&ready cycles; addresses stay contiguous 0..24; a single start pulse.
- Readback: the BRAM model preloads addresses 9..16 with 0x1AAAA+i, then mm_done_i is pulsed. Required: 8 reads at addresses 9..16; res_data_o equals 0x1AAAA..0x1AAB1 in order; done_o pulses once after the 8th accept; busy_o returns to 0.
- Result backpressure: res_ready_i held low for 5 cycles on word 3. Required: res_data_o and res_valid_o stay stable throughout; no BRAM read is issued; the word is accepted intact once ready rises.
- Timeout: TIMEOUT=100 and mm_done_i never asserted. Required: err_o=1 at cycle 100 of WAIT; state returns to IDLE with no res_valid_o; err_o clears on the next accepted operand.
- Reset mid-load: reset_n_i pulsed low after word 10. Required: all outputs 0 asynchronously, no start pulse; a fresh 25-word load then completes normally starting at address 0.
